// File: rtl/mul_add_row_pkg.sv
// rtl/mul_add_row_pkg.sv - shared defaults, FSM encoding and counter sizing for mul_add_row
package mul_add_row_pkg;

  // Default geometry: 4096-bit operands split into 32-bit words.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WORDS  = 128;
  localparam int DEF_MUL_STAGES = 2;

  // Counters must reach NUM_WORDS itself, hence the +1.
  localparam int DEF_CNT_W = $clog2(DEF_NUM_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width for an arbitrary row length.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mul_add_row_mul_pipe.sv
// rtl/mul_add_row_mul_pipe.sv - W x W -> 2W multiplier with enable-gated register pipeline
module mul_pipe
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     x,
  input  logic [DATA_WIDTH-1:0]     y,
  input  logic [DATA_WIDTH-1:0]     z,
  output logic                      p_valid,
  output logic [2*DATA_WIDTH-1:0]   p,
  output logic [DATA_WIDTH-1:0]     z_dly
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0]        prod;
  logic [2*W-1:0]        p_q [MUL_STAGES];
  logic [W-1:0]          z_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] v_q;

  // Full-width product; the stages below let synthesis retime it.
  assign prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};

  // Valid bits shift alongside the data so bubbles stay aligned with their slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else if (en) begin
      v_q[0] <= load;
      for (int i = 1; i < MUL_STAGES; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  // Product and addend travel together through identical stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        p_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else if (en) begin
      p_q[0] <= prod;
      z_q[0] <= z;
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_q[i] <= p_q[i-1];
        z_q[i] <= z_q[i-1];
      end
    end
  end

  assign p_valid = v_q[MUL_STAGES-1];
  assign p       = p_q[MUL_STAGES-1];
  assign z_dly   = z_q[MUL_STAGES-1];

endmodule

// File: rtl/mul_add_row.sv
// rtl/mul_add_row.sv - pipelined word-serial multiply-add row engine with chained carry
module mul_add_row
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] s_out,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] c_final,
  output logic                  done,
  output logic                  busy
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] WORDS_C    = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(NUM_WORDS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [W-1:0]     y_reg;
  logic [W-1:0]     c_reg;
  logic             en;
  logic             accept;
  logic             row_start;
  logic             row_end;
  logic             pipe_valid;
  logic [2*W-1:0]   pipe_p;
  logic [W-1:0]     pipe_z;
  logic [2*W-1:0]   sum;

  // One stall signal freezes the whole pipe while the output word is unaccepted.
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = (state_q == ST_RUN) && en && (issue_cnt < WORDS_C);
  assign accept    = in_valid && in_ready;
  assign row_start = (state_q == ST_IDLE) && start;
  assign row_end   = out_valid && out_ready && out_last;

  // (2^W-1)^2 + 2(2^W-1) = 2^2W - 1, so 2W bits always hold the sum.
  assign sum = pipe_p + {{W{1'b0}}, pipe_z} + {{W{1'b0}}, c_reg};

  mul_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (accept),
    .x       (x_in),
    .y       (y_reg),
    .z       (z_in),
    .p_valid (pipe_valid),
    .p       (pipe_p),
    .z_dly   (pipe_z)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && (issue_cnt == LAST_IDX_C)) state_d = ST_DRAIN;
      ST_DRAIN: if (row_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign done = (state_q == ST_DONE);
  assign busy = (state_q != ST_IDLE);

  // Row multiplier is latched once per row so y_in may change freely afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg <= '0;
    end else if (row_start) begin
      y_reg <= y_in;
    end
  end

  // Issue/retire counters and the word-to-word carry; carry only moves on real words.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt  <= '0;
      retire_cnt <= '0;
      c_reg      <= '0;
    end else if (row_start) begin
      issue_cnt  <= '0;
      retire_cnt <= '0;
      c_reg      <= c_init;
    end else begin
      if (accept) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (en && pipe_valid) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        c_reg      <= sum[2*W-1:W];
      end
    end
  end

  // Output register: loads the low half of the sum, holds under stall and bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      s_out     <= '0;
    end else if (en) begin
      out_valid <= pipe_valid;
      out_last  <= pipe_valid && (retire_cnt == LAST_IDX_C);
      if (pipe_valid) begin
        s_out <= sum[W-1:0];
      end
    end
  end

  // c_reg already carries the last word's high half when that word leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_final <= '0;
    end else if (row_end) begin
      c_final <= c_reg;
    end
  end

endmodule

// File: tb/tb_mul_add_row.sv
// tb/tb_mul_add_row.sv - directed table-driven bench for mul_add_row (W=8, N=4, 2 stages)
module tb_mul_add_row;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MS = 2;

  typedef struct {
    logic [7:0]      y;
    logic [7:0]      c;
    logic [3:0][7:0] x;
    logic [3:0][7:0] z;
    logic [3:0][7:0] s;
    logic [7:0]      cf;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] y_in;
  logic [W-1:0] c_init;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s_out;
  logic         out_last;
  logic [W-1:0] c_final;
  logic         done;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t       vecs [4];
  logic [7:0] got_s [8];
  logic       got_last [8];
  int         n_out, n_done, lat, hold_bad, ready_bad, busy_bad, timeout;
  int         stall_seen, post_busy, post_done;

  always #5 clk = ~clk;

  mul_add_row #(
    .DATA_WIDTH (W),
    .NUM_WORDS  (N),
    .MUL_STAGES (MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .y_in      (y_in),
    .c_init    (c_init),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .out_last  (out_last),
    .c_final   (c_final),
    .done      (done),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one row; optional output stall after word stall_after, input gap after word gap_after,
  // and ignored start pulses during RUN and in the DONE cycle.
  task automatic run_row(input vec_t v, input int stall_after, input int gap_after, input bit busy_start);
    int   issued, acc0, stall_left, gap_left;
    bit   stall_done, gap_done, inj, hs_last_prev, held_ok;
    logic [7:0] held;
    issued = 0; acc0 = 0; stall_left = 0; gap_left = 0;
    stall_done = 0; gap_done = 0; inj = 0; hs_last_prev = 0; held_ok = 0; held = '0;
    n_out = 0; n_done = 0; lat = -1; hold_bad = 0; ready_bad = 0; busy_bad = 0; timeout = 1;
    start = 1'b1; y_in = v.y; c_init = v.c; in_valid = 1'b0; out_ready = 1'b1;
    step();
    for (int cyc = 0; cyc < 100; cyc++) begin
      start = 1'b0; y_in = 8'hEE; c_init = 8'hEE;
      if (stall_after >= 0 && !stall_done && n_out == stall_after) begin
        stall_left = 5; stall_done = 1;
      end
      if (gap_after >= 0 && !gap_done && issued == gap_after) begin
        gap_left = 2; gap_done = 1;
      end
      if (busy_start && !inj && issued == 1) begin
        start = 1'b1; y_in = 8'h07; c_init = 8'h77; inj = 1;
      end
      if (busy_start && hs_last_prev) begin
        start = 1'b1; y_in = 8'h07; c_init = 8'h77;
      end
      out_ready = (stall_left == 0);
      in_valid  = (issued < N) && (gap_left == 0);
      x_in      = in_valid ? v.x[issued[1:0]] : 8'hCC;
      z_in      = in_valid ? v.z[issued[1:0]] : 8'hCC;
      #1;
      hs_last_prev = 0;
      if (busy !== 1'b1) busy_bad++;
      if (stall_left > 0 && out_valid) begin
        if (!held_ok) begin
          held = s_out; held_ok = 1;
        end else if (s_out !== held) begin
          hold_bad++;
        end
        if (in_ready !== 1'b0) ready_bad++;
      end
      if (out_valid && lat < 0 && issued > 0) lat = cyc - acc0;
      if (out_valid && out_ready) begin
        if (n_out < 8) begin
          got_s[n_out] = s_out; got_last[n_out] = out_last;
        end
        n_out++;
        hs_last_prev = out_last;
      end
      if (in_valid && in_ready) begin
        if (issued == 0) acc0 = cyc;
        issued++;
      end
      if (done) begin
        n_done++; timeout = 0;
        break;
      end
      if (stall_left > 0) stall_left--;
      if (gap_left > 0) gap_left--;
      step();
    end
    stall_seen = held_ok;
    step();
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    post_busy = busy; post_done = done;
    for (int k = 0; k < 3; k++) begin
      if (done) n_done++;
      step();
    end
  endtask

  task automatic check_row(input string tag, input vec_t v);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s s[%0d]", tag, i), got_s[i], v.s[i]);
      check($sformatf("%s last[%0d]", tag, i), got_last[i], (i == N - 1));
    end
    check({tag, " c_final"}, c_final, v.cf);
    check({tag, " n_out"}, n_out, N);
    check({tag, " n_done"}, n_done, 1);
    check({tag, " busy_gap"}, busy_bad, 0);
    check({tag, " busy_after"}, post_busy, 0);
    check({tag, " timeout"}, timeout, 0);
  endtask

  initial begin
    // y, c_init, x{3..0}, z{3..0}, expected s{3..0}, expected c_final
    vecs[0] = '{8'h02, 8'h00, {8'h04, 8'h03, 8'h02, 8'h01}, 32'h0,
                {8'h08, 8'h06, 8'h04, 8'h02}, 8'h00};
    vecs[1] = '{8'h10, 8'h00, {8'h10, 8'h10, 8'h10, 8'h10}, 32'h0,
                {8'h01, 8'h01, 8'h01, 8'h00}, 8'h01};
    vecs[2] = '{8'h03, 8'h05, {8'h01, 8'h80, 8'hAA, 8'h55}, {8'h04, 8'h03, 8'h02, 8'h01},
                {8'h08, 8'h85, 8'h01, 8'h05}, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF};

    reset = 1'b1; start = 1'b0; y_in = '0; c_init = '0;
    in_valid = 1'b0; x_in = '0; z_in = '0; out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst s_out", s_out, 0);
    check("rst out_last", out_last, 0);
    check("rst c_final", c_final, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);

    for (int r = 0; r < 4; r++) begin
      run_row(vecs[r], -1, -1, 1'b0);
      check_row($sformatf("row%0d", r), vecs[r]);
      if (r == 0) check("row0 latency", lat, MS + 1);
    end

    // Output stall after word 1 plus a two-cycle input gap after word 1.
    run_row(vecs[1], 2, 2, 1'b0);
    check_row("bp", vecs[1]);
    check("bp stall_seen", stall_seen, 1);
    check("bp s_hold", hold_bad, 0);
    check("bp in_ready_low", ready_bad, 0);

    // Reset after two words accepted.
    start = 1'b1; y_in = vecs[0].y; c_init = vecs[0].c;
    step();
    start = 1'b0;
    begin
      int acc;
      acc = 0;
      for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
        in_valid = 1'b1; x_in = vecs[0].x[acc[1:0]]; z_in = 8'h00;
        #1;
        if (in_ready) acc++;
        step();
      end
      check("mid accepted", acc, 2);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid in_ready", in_ready, 0);
    check("mid out_valid", out_valid, 0);
    check("mid s_out", s_out, 0);
    check("mid out_last", out_last, 0);
    check("mid c_final", c_final, 0);
    check("mid done", done, 0);
    check("mid busy", busy, 0);
    in_valid = 1'b0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 8; k++) begin
        if (done || out_valid || busy) stray++;
        step();
      end
      check("mid no_activity", stray, 0);
    end
    run_row(vecs[0], -1, -1, 1'b0);
    check_row("after_rst", vecs[0]);

    // Start pulses during RUN and in the DONE cycle must be ignored.
    run_row(vecs[0], -1, -1, 1'b1);
    check_row("busy_start", vecs[0]);
    check("busy_start post_done", post_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_add_row.md
Name: mul_add_row

Overview:
Pipelined, parametrised word-serial multiply-add row engine for the MonPro datapath. Computes one full row of s[i] = low(x[i]*y + z[i] + c), c = high(...), for i = 0..NUM_WORDS-1. The carry is chained internally from word to word; the row's final carry is returned at the end. It replaces per-word combinational multiply-add instances, adds a registered multiplier pipeline and valid/ready flow control, and sits between the MonPro operand RAM readers and the result writer.

Parameters:
DATA_WIDTH, 32, word width W of x, y, z, s and c.
NUM_WORDS, 128, words per row (4096/32); must be >= 1.
MUL_STAGES, 2, register stages in the multiplier path; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  1-cycle pulse; captures y_in and c_init, begins a row; ignored when busy=1.
y_in  input  W  row multiplier word, held internally for the whole row.
c_init  input  W  initial carry for word 0.
in_valid  input  1  x_in/z_in valid.
in_ready  output  1  engine accepts a word this cycle.
x_in  input  W  multiplicand word i.
z_in  input  W  addend word i.
out_valid  output  1  s_out valid.
out_ready  input  1  downstream accepts s_out.
s_out  output  W  result word i.
out_last  output  1  s_out is word NUM_WORDS-1.
c_final  output  W  row carry-out; held until the next start.
done  output  1  1-cycle pulse when the row completes.
busy  output  1  high from start until done (inclusive).

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: in_ready=0, out_valid=0, s_out=0, out_last=0, c_final=0, done=0, busy=0. All counters, the carry register and pipeline valid bits are cleared.
- FSM states: IDLE -> (start) RUN -> (last word issued) DRAIN -> (last word retired) DONE -> IDLE. DONE lasts one cycle and asserts done.
- A reset asserted in any state returns the FSM to IDLE on the next edge. In-flight words are discarded and no done pulse is produced.
- Global pipeline enable en = !(out_valid && !out_ready). When en=0, every stage, the carry register and the s_out/out_last outputs hold their values.
- in_ready = (state==RUN) && en && (issue_cnt < NUM_WORDS). A word is accepted on in_valid && in_ready.
- Multiplier path: p = x*y, computed over MUL_STAGES registers. z is delayed alongside p.
- Final add stage: sum = p + z + c_reg, 2W bits wide. It cannot overflow, since (2^W-1)^2 + 2(2^W-1) = 2^2W - 1. On output: s_out = sum[W-1:0] and c_reg <= sum[2W-1:W]. c_reg is loaded with c_init at start.
- Latency: a word accepted at cycle t gives out_valid at t+MUL_STAGES+1 when there is no stall. Throughput is 1 word/cycle.
- Output order equals input order. out_last is asserted with word NUM_WORDS-1.
- Row completion: when the last word handshakes on the output (out_valid && out_ready && out_last):
  - c_final <= final carry;
  - next state DONE; done pulses in the following cycle;
  - busy drops in the cycle after done.
- Gaps in in_valid are legal and produce bubbles; the carry chain is unaffected by bubbles.
- A start pulse while busy=1 is ignored, including in the DONE cycle.
- With NUM_WORDS=1, the FSM goes directly RUN -> DRAIN after one accept.
- Counters are $clog2(NUM_WORDS+1) bits wide and do not wrap within a row.

Decomposition:
- Shared package/include: DATA_WIDTH default, NUM_WORDS, the FSM state encoding constants, and a CNT_W localparam derived from NUM_WORDS.
- One sub-module: mul_pipe, a W x W -> 2W multiplier with MUL_STAGES registers, an enable input, and a valid shift chain carrying z alongside.
- FSM, counters, carry register and output register stay in mul_add_row.

Test Plan:
1. Basic, W=8, N=4, MUL_STAGES=2: y=2, c_init=0, x={1,2,3,4}, z=0, out_ready=1 -> s={02,04,06,08}; c_final=00; first out_valid 3 cycles after the first accept; done after word 3.
2. Carry chain, W=8: y=0x10, x={10,10,10,10}, z=0, c_init=0 -> s={00,01,01,01}; c_final=01.
3. Max values, W=8: y=FF, x=FF, z=FF, c_init=FF for all words -> every s=FF; c_final=FF; no overflow.
4. Backpressure and bubbles: drop out_ready for 5 cycles after word 1 and leave a 2-cycle gap in in_valid -> s_out held stable while stalled; in_ready=0 while stalled; same result sequence as scenario 2; exactly 4 output handshakes.
5. Reset mid-row: assert reset after 2 words accepted -> next cycle all outputs are at reset values and no done pulse. A fresh start then completes scenario 1 correctly.
6. Start while busy: pulse start with y_in=7 during RUN -> ignored; row results still use the original y; busy stays continuous; a single done pulse.
